countdown_timer: RTL

Loadable down-counter that pairs with the free-running up-counter. An up-counter measures elapsed cycles; this block counts a programmed number of ticks down to zero and signals expiry. A requester loads a start value over a valid/ready handshake. The block decrements once per prescaled tick, pulses `done` when it reaches zero, and can optionally reload itself for periodic operation. Typical users are timeouts and periodic event generation in the same clock domain.

---
 rtl/countdown_timer.sv | 104 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter: counts a programmed number of prescaled ticks to zero,
// pulses done on expiry and optionally reloads itself for periodic operation.
module countdown_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload_reg;
   logic [PW-1:0]    presc_cnt;
   logic             active;
   logic             advance;
   logic             tick;
   logic             terminal;
   logic             accept;

   // A PAUSED cycle with pause released already counts, so a pause of N
   // cycles delays expiry by exactly N cycles.
   assign active   = (state != IDLE);
   assign advance  = active && !abort && !pause;
   assign tick     = advance && (presc_cnt == PRESC_MAX);
   assign terminal = tick && (count == WIDTH'(1));
   assign accept   = (state == IDLE) && load_valid;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load_valid && (load_value != '0)) state_nxt = RUN;
         end
         RUN, PAUSED: begin
            if (abort)                          state_nxt = IDLE;
            else if (pause)                     state_nxt = PAUSED;
            else if (terminal && !auto_reload)  state_nxt = IDLE;
            else                                state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == RUN) || (state == PAUSED);
      load_ready = (state == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count      <= '0;
         reload_reg <= '0;
         presc_cnt  <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (load_value != '0) begin
               count      <= load_value;
               reload_reg <= load_value;
               presc_cnt  <= '0;
            end else begin
               done <= 1'b1;
            end
         end else if (active && abort) begin
            count     <= '0;
            presc_cnt <= '0;
         end else if (advance) begin
            if (tick) begin
               presc_cnt <= '0;
               if (terminal) begin
                  done  <= 1'b1;
                  count <= auto_reload ? reload_reg : '0;
               end else begin
                  count <= count - WIDTH'(1);
               end
            end else begin
               presc_cnt <= presc_cnt + PW'(1);
            end
         end
      end
   end

endmodule
